// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner selection for one shared rollover counter.
// Grants one requester at a time, loads the counter's rollover value, clears
// it, gates its enable (with a global hold) and pulses done on rollover.
module timer_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] period,
  input  logic                            hold,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic                            cnt_clear,
  output logic                            cnt_enable,
  output logic [NUM_CNT_BITS-1:0]         cnt_rollover_val,
  input  logic                            cnt_rollover_flag
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        ptr_reg, ptr_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [NUM_CNT_BITS-1:0] per_reg, per_next;

  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic [IDX_W-1:0]        idx_succ;
  logic [NUM_CNT_BITS-1:0] period_slice [NUM_REQ];

  // Unpack the flat period bus and decode the one-hot grant/done vectors.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign period_slice[gi] = period[gi*NUM_CNT_BITS +: NUM_CNT_BITS];
      assign grant[gi] = (state_reg != IDLE) && (idx_reg == IDX_W'(gi));
      assign done[gi]  = (state_reg == DONE) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Counter controls come from registered state; only the enable also looks
  // at hold and the flag so the counter stops exactly on N without wrapping.
  assign busy             = (state_reg != IDLE);
  assign cnt_clear        = (state_reg == LOAD) || (state_reg == DONE);
  assign cnt_enable       = (state_reg == RUN) && !hold && !cnt_rollover_flag;
  assign cnt_rollover_val = per_reg;

  // Pointer for the next search starts just past the owner being released.
  assign idx_succ = (idx_reg == IDX_W'(NUM_REQ-1)) ? '0 : idx_reg + 1'b1;

  // Round-robin pick: first set req at or above ptr, wrapping around.
  // Scanning offsets downward lets the smallest offset win.
  always_comb begin
    int               c;
    logic [IDX_W-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      c = int'(ptr_reg) + k;
      if (c >= NUM_REQ) begin
        c = c - NUM_REQ;
      end
      cand = IDX_W'(c);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, load, run until rollover, report.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    per_next   = per_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          idx_next   = pick_idx;
          per_next   = period_slice[pick_idx];
          state_next = LOAD;
        end
      end
      LOAD: begin
        // A zero-length interval skips the counter entirely.
        state_next = (per_reg == '0) ? DONE : RUN;
      end
      RUN: begin
        // Rollover wins over an abandon seen in the same cycle.
        if (cnt_rollover_flag) begin
          state_next = DONE;
        end else if (!req[idx_reg]) begin
          ptr_next   = idx_succ;
          state_next = IDLE;
        end
      end
      DONE: begin
        ptr_next   = idx_succ;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and arbitration registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      per_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      per_reg   <= per_next;
    end
  end

endmodule
